// File: rtl/mii_lock_pattern_checker.sv
// -----------------------------------------------------------------------------
// mii_lock_pattern_checker
//
// Checks each valid word of NB = DATA_WIDTH/8 octets against a run-time data
// pattern (octets with ctrl_i low) and control pattern (octets with ctrl_i
// high). Lock is acquired after LOCK_THRESHOLD consecutive clean words and
// dropped after LOSS_THRESHOLD consecutive errored words. While locked, the
// octet statistics (saturating), a lock-loss counter and a first-error
// snapshot are maintained.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable_i              checker enable; low forces IDLE on the next edge
//   clear_i               synchronous clear of counters and snapshot
//   valid_i               word qualifier; there is no back-pressure, a word is
//                         consumed on every edge where valid_i is high
//   data_i / ctrl_i       octet bus and per-octet control flags
//   data_pattern_i        expected data octet
//   ctrl_pattern_i        expected control octet
//   state_o / locked_o    FSM state (0 IDLE, 1 HUNT, 2 LOCKED) and lock flag
//   *_count               saturating statistics counters
//   first_err_valid/mask  error mask of the first counted errored word
// -----------------------------------------------------------------------------
module mii_lock_pattern_checker #(
  parameter int DATA_WIDTH     = 64,
  parameter int COUNTER_WIDTH  = 32,
  parameter int LOCK_THRESHOLD = 4,
  parameter int LOSS_THRESHOLD = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic                     valid_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic [DATA_WIDTH/8-1:0]  ctrl_i,
  input  logic [7:0]               data_pattern_i,
  input  logic [7:0]               ctrl_pattern_i,
  output logic [1:0]               state_o,
  output logic                     locked_o,
  output logic [COUNTER_WIDTH-1:0] total_char_count,
  output logic [COUNTER_WIDTH-1:0] data_char_count,
  output logic [COUNTER_WIDTH-1:0] ctrl_char_count,
  output logic [COUNTER_WIDTH-1:0] data_error_count,
  output logic [COUNTER_WIDTH-1:0] ctrl_error_count,
  output logic [COUNTER_WIDTH-1:0] lock_loss_count,
  output logic                     first_err_valid,
  output logic [DATA_WIDTH/8-1:0]  first_err_mask
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int PW  = $clog2(NB + 1);
  localparam int CRW = $clog2(LOCK_THRESHOLD + 1);
  localparam int ERW = $clog2(LOSS_THRESHOLD + 1);
  localparam int CW  = COUNTER_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [CRW-1:0] clean_run, clean_run_next;
  logic [ERW-1:0] err_run, err_run_next;
  logic           loss_event;

  logic [NB-1:0]  err;
  logic           word_err;
  logic           count_en;

  function automatic logic [PW-1:0] popcount(input logic [NB-1:0] v);
    logic [PW-1:0] s;
    s = '0;
    for (int i = 0; i < NB; i++) s = s + PW'(v[i]);
    return s;
  endfunction

  // Sum is formed wide enough to never overflow, then clamped.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                            input logic [PW-1:0] b);
    logic [CW+PW-1:0] s;
    s = (CW+PW)'(a) + (CW+PW)'(b);
    return (s > (CW+PW)'({CW{1'b1}})) ? {CW{1'b1}} : s[CW-1:0];
  endfunction

  // Per-octet comparison against the pattern selected by the control flag.
  always_comb begin
    err = '0;
    for (int i = 0; i < NB; i++) begin
      err[i] = ctrl_i[i] ? (data_i[8*i +: 8] != ctrl_pattern_i)
                         : (data_i[8*i +: 8] != data_pattern_i);
    end
  end

  assign word_err = |err;

  // Words are only counted while the enabled checker sits in LOCKED; the word
  // that triggers lock loss is still counted because state is still LOCKED.
  assign count_en = valid_i && enable_i && (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clean_run <= '0;
      err_run   <= '0;
    end else begin
      state     <= state_next;
      clean_run <= clean_run_next;
      err_run   <= err_run_next;
    end
  end

  always_comb begin
    state_next     = state;
    clean_run_next = clean_run;
    err_run_next   = err_run;
    loss_event     = 1'b0;
    if (!enable_i) begin
      state_next     = IDLE;
      clean_run_next = '0;
      err_run_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next     = HUNT;
          clean_run_next = '0;
          err_run_next   = '0;
        end
        HUNT: begin
          if (valid_i) begin
            if (word_err) begin
              clean_run_next = '0;
            end else if (clean_run == CRW'(LOCK_THRESHOLD - 1)) begin
              state_next     = LOCKED;
              clean_run_next = '0;
              err_run_next   = '0;
            end else begin
              clean_run_next = clean_run + CRW'(1);
            end
          end
        end
        LOCKED: begin
          if (valid_i) begin
            if (!word_err) begin
              err_run_next = '0;
            end else if (err_run == ERW'(LOSS_THRESHOLD - 1)) begin
              state_next     = HUNT;
              loss_event     = 1'b1;
              clean_run_next = '0;
              err_run_next   = '0;
            end else begin
              err_run_next = err_run + ERW'(1);
            end
          end
        end
        default: begin
          state_next     = IDLE;
          clean_run_next = '0;
          err_run_next   = '0;
        end
      endcase
    end
  end

  // Statistics and snapshot; clear wins over anything this word contributes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_char_count <= '0;
      data_char_count  <= '0;
      ctrl_char_count  <= '0;
      data_error_count <= '0;
      ctrl_error_count <= '0;
      lock_loss_count  <= '0;
      first_err_valid  <= 1'b0;
      first_err_mask   <= '0;
    end else if (clear_i) begin
      total_char_count <= '0;
      data_char_count  <= '0;
      ctrl_char_count  <= '0;
      data_error_count <= '0;
      ctrl_error_count <= '0;
      lock_loss_count  <= '0;
      first_err_valid  <= 1'b0;
      first_err_mask   <= '0;
    end else begin
      if (count_en) begin
        total_char_count <= sat_add(total_char_count, PW'(NB));
        data_char_count  <= sat_add(data_char_count, popcount(~ctrl_i));
        ctrl_char_count  <= sat_add(ctrl_char_count, popcount(ctrl_i));
        data_error_count <= sat_add(data_error_count, popcount(err & ~ctrl_i));
        ctrl_error_count <= sat_add(ctrl_error_count, popcount(err & ctrl_i));
        if (word_err && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_mask  <= err;
        end
      end
      if (loss_event) begin
        lock_loss_count <= sat_add(lock_loss_count, PW'(1));
      end
    end
  end

  assign state_o  = state;
  assign locked_o = (state == LOCKED);

endmodule

// File: tb/tb_mii_lock_pattern_checker.sv
module tb_mii_lock_pattern_checker;

  localparam int DW  = 64;
  localparam int NB  = DW / 8;
  localparam int CW  = 8;
  localparam int LT  = 4;
  localparam int LS  = 3;
  localparam int SAT = (1 << CW) - 1;

  localparam logic [63:0] CLEAN_AA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] ERR1_AA  = 64'hAAAA_AAAA_AAAA_00AA;
  localparam logic [63:0] CTRL_AA  = 64'hAAAA_AAAA_AAAA_AA54;
  localparam logic [63:0] CLEAN_3C = 64'h3C3C_3C3C_3C3C_3C3C;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          enable_i, clear_i, valid_i;
  logic [DW-1:0] data_i;
  logic [NB-1:0] ctrl_i;
  logic [7:0]    data_pattern_i, ctrl_pattern_i;
  logic [1:0]    state_o;
  logic          locked_o;
  logic [CW-1:0] total_char_count, data_char_count, ctrl_char_count;
  logic [CW-1:0] data_error_count, ctrl_error_count, lock_loss_count;
  logic          first_err_valid;
  logic [NB-1:0] first_err_mask;

  mii_lock_pattern_checker #(
    .DATA_WIDTH(DW), .COUNTER_WIDTH(CW),
    .LOCK_THRESHOLD(LT), .LOSS_THRESHOLD(LS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .clear_i(clear_i),
    .valid_i(valid_i), .data_i(data_i), .ctrl_i(ctrl_i),
    .data_pattern_i(data_pattern_i), .ctrl_pattern_i(ctrl_pattern_i),
    .state_o(state_o), .locked_o(locked_o),
    .total_char_count(total_char_count), .data_char_count(data_char_count),
    .ctrl_char_count(ctrl_char_count), .data_error_count(data_error_count),
    .ctrl_error_count(ctrl_error_count), .lock_loss_count(lock_loss_count),
    .first_err_valid(first_err_valid), .first_err_mask(first_err_mask)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int total_checks = 0;
  int bad_checks   = 0;
  bit cmp_on       = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp) begin
      bad_checks++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_mode: 0 idle, 1 hunting, 2 locked. A single run length is enough: it
  // counts clean words while hunting and errored words while locked.
  int m_mode, m_run;
  int m_total, m_data, m_ctrl, m_derr, m_cerr, m_loss;
  int m_fev, m_fmask;

  function automatic int sat(input int x);
    return (x > SAT) ? SAT : x;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_run = 0;
    m_total = 0; m_data = 0; m_ctrl = 0; m_derr = 0; m_cerr = 0; m_loss = 0;
    m_fev = 0; m_fmask = 0;
  endtask

  task automatic model_step(input bit en, input bit clr, input bit v,
                            input logic [63:0] d, input logic [7:0] c,
                            input logic [7:0] dp, input logic [7:0] cp);
    int mask, nd, nc, nde, nce;
    bit counted, loss;
    mask = 0; nd = 0; nc = 0; nde = 0; nce = 0;
    for (int i = 0; i < NB; i++) begin
      logic [7:0] o;
      o = d[8*i +: 8];
      if (c[i]) begin
        nc++;
        if (o != cp) begin nce++; mask |= (1 << i); end
      end else begin
        nd++;
        if (o != dp) begin nde++; mask |= (1 << i); end
      end
    end
    counted = en && v && (m_mode == 2);
    loss = 1'b0;
    if (!en) begin
      m_mode = 0; m_run = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_run = 0;
    end else if (v && m_mode == 1) begin
      if (mask != 0) m_run = 0;
      else begin
        m_run++;
        if (m_run == LT) begin m_mode = 2; m_run = 0; end
      end
    end else if (v && m_mode == 2) begin
      if (mask == 0) m_run = 0;
      else begin
        m_run++;
        if (m_run == LS) begin m_mode = 1; m_run = 0; loss = 1'b1; end
      end
    end
    if (clr) begin
      m_total = 0; m_data = 0; m_ctrl = 0; m_derr = 0; m_cerr = 0; m_loss = 0;
      m_fev = 0; m_fmask = 0;
    end else begin
      if (counted) begin
        m_total = sat(m_total + NB);
        m_data  = sat(m_data + nd);
        m_ctrl  = sat(m_ctrl + nc);
        m_derr  = sat(m_derr + nde);
        m_cerr  = sat(m_cerr + nce);
        if (mask != 0 && m_fev == 0) begin m_fev = 1; m_fmask = mask; end
      end
      if (loss) m_loss = sat(m_loss + 1);
    end
  endtask

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #2;
    if (cmp_on) begin
      chk("state", 32'(state_o), 32'(m_mode));
      chk("locked", 32'(locked_o), 32'(m_mode == 2));
      chk("total", 32'(total_char_count), 32'(m_total));
      chk("data", 32'(data_char_count), 32'(m_data));
      chk("ctrl", 32'(ctrl_char_count), 32'(m_ctrl));
      chk("data_err", 32'(data_error_count), 32'(m_derr));
      chk("ctrl_err", 32'(ctrl_error_count), 32'(m_cerr));
      chk("lock_loss", 32'(lock_loss_count), 32'(m_loss));
      chk("fe_valid", 32'(first_err_valid), 32'(m_fev));
      chk("fe_mask", 32'(first_err_mask), 32'(m_fmask));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit en, input bit clr, input bit v,
                       input logic [63:0] d, input logic [7:0] c,
                       input logic [7:0] dp, input logic [7:0] cp);
    @(negedge clk);
    enable_i = en; clear_i = clr; valid_i = v;
    data_i = d; ctrl_i = c; data_pattern_i = dp; ctrl_pattern_i = cp;
    model_step(en, clr, v, d, c, dp, cp);
  endtask

  task automatic word(input logic [63:0] d, input logic [7:0] c);
    drive(1'b1, 1'b0, 1'b1, d, c, 8'hAA, 8'h55);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    enable_i = 1'b0; clear_i = 1'b0; valid_i = 1'b0;
    data_i = '0; ctrl_i = '0; data_pattern_i = 8'hAA; ctrl_pattern_i = 8'h55;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_total", 32'(total_char_count), 32'd0);
    chk("rst_fe_valid", 32'(first_err_valid), 32'd0);
    rst_n = 1'b1;
    cmp_on = 1'b1;

    // Enable, then four clean words acquire lock.
    drive(1'b1, 1'b0, 1'b0, '0, 8'h00, 8'hAA, 8'h55);
    repeat (3) word(CLEAN_AA, 8'h00);
    settle();
    chk("t1_hunt_after3", 32'(state_o), 32'd1);
    word(CLEAN_AA, 8'h00);
    settle();
    chk("t1_locked", 32'(state_o), 32'd2);
    chk("t1_total0", 32'(total_char_count), 32'd0);
    word(CLEAN_AA, 8'h00);
    settle();
    chk("t1_total8", 32'(total_char_count), 32'd8);
    chk("t1_data8", 32'(data_char_count), 32'd8);
    chk("t1_derr0", 32'(data_error_count), 32'd0);

    // Mismatched control octet captures the snapshot.
    word(CTRL_AA, 8'h01);
    settle();
    chk("t2_ctrl", 32'(ctrl_char_count), 32'd1);
    chk("t2_cerr", 32'(ctrl_error_count), 32'd1);
    chk("t2_data", 32'(data_char_count), 32'd15);
    chk("t2_mask", 32'(first_err_mask), 32'h01);
    chk("t2_fev", 32'(first_err_valid), 32'd1);
    word(CLEAN_AA, 8'h00);

    // 2 errored, 1 clean, 3 errored: lock lost on the sixth word only.
    word(ERR1_AA, 8'h00);
    word(ERR1_AA, 8'h00);
    word(CLEAN_AA, 8'h00);
    word(ERR1_AA, 8'h00);
    word(ERR1_AA, 8'h00);
    settle();
    chk("t3_still_locked", 32'(state_o), 32'd2);
    word(ERR1_AA, 8'h00);
    settle();
    chk("t3_hunt", 32'(state_o), 32'd1);
    chk("t3_loss", 32'(lock_loss_count), 32'd1);
    chk("t3_total", 32'(total_char_count), 32'd72);
    chk("t3_derr", 32'(data_error_count), 32'd5);
    chk("t3_mask_held", 32'(first_err_mask), 32'h01);

    // Clear while hunting, then 3 clean, 1 errored, 4 clean.
    drive(1'b1, 1'b1, 1'b0, '0, 8'h00, 8'hAA, 8'h55);
    repeat (3) word(CLEAN_AA, 8'h00);
    word(ERR1_AA, 8'h00);
    repeat (3) word(CLEAN_AA, 8'h00);
    settle();
    chk("t4_hunt", 32'(state_o), 32'd1);
    word(CLEAN_AA, 8'h00);
    settle();
    chk("t4_locked", 32'(state_o), 32'd2);
    chk("t4_total0", 32'(total_char_count), 32'd0);
    chk("t4_loss0", 32'(lock_loss_count), 32'd0);

    // Saturation, then clear together with a counted word.
    repeat (40) word(CLEAN_AA, 8'h00);
    settle();
    chk("t5_total_sat", 32'(total_char_count), 32'hFF);
    chk("t5_data_sat", 32'(data_char_count), 32'hFF);
    drive(1'b1, 1'b1, 1'b1, ERR1_AA, 8'h00, 8'hAA, 8'h55);
    settle();
    chk("t5_clr_total", 32'(total_char_count), 32'd0);
    chk("t5_clr_derr", 32'(data_error_count), 32'd0);
    chk("t5_clr_fev", 32'(first_err_valid), 32'd0);
    chk("t5_clr_state", 32'(state_o), 32'd2);

    // Different data pattern, then drop and restore enable.
    drive(1'b1, 1'b0, 1'b1, CLEAN_3C, 8'h00, 8'h3C, 8'h55);
    drive(1'b1, 1'b0, 1'b1, CLEAN_3C, 8'h00, 8'h3C, 8'h55);
    drive(1'b0, 1'b0, 1'b0, '0, 8'h00, 8'hAA, 8'h55);
    settle();
    chk("t6_idle", 32'(state_o), 32'd0);
    chk("t6_total_hold", 32'(total_char_count), 32'd16);
    drive(1'b1, 1'b0, 1'b0, '0, 8'h00, 8'hAA, 8'h55);
    repeat (3) word(CLEAN_AA, 8'h00);
    settle();
    chk("t6_hunt", 32'(state_o), 32'd1);
    word(CLEAN_AA, 8'h00);
    settle();
    chk("t6_relock", 32'(state_o), 32'd2);

    // Asynchronous reset in the middle of a word.
    word(ERR1_AA, 8'h00);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t7_rst_state", 32'(state_o), 32'd0);
    chk("t7_rst_total", 32'(total_char_count), 32'd0);
    chk("t7_rst_fev", 32'(first_err_valid), 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0, 8'h00, 8'hAA, 8'h55);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, 8'h00, 8'hAA, 8'h55);
    settle();
    cmp_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
